pipeline_hazard_ctrl: RTL

//  Central stall/flush/forward sequencer for the 5-stage RV32 pipeline.

---
 rtl/pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer for a 5-stage RV32 pipeline.
// Control outputs are combinational from state + inputs. The FSM state and the
// performance counters are registered. Outputs are prioritised as:
// ERROR > data-memory stall > taken branch > load-use > normal advance.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             ex_mem_flush,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state,
    output logic             mem_err
);

    // wait_cnt counts the stalled cycles of the current memory wait, up to MEM_TIMEOUT-1
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_next_wait_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_mem_stall;
    logic             w_load_use;
    logic             w_stall_inc;
    logic             w_flush_inc;

    assign w_mem_stall = (r_state != ST_ERROR) & dmem_req & ~dmem_ready;
    assign w_load_use  = ex_mem_read & (ex_rd != 5'd0) &
                         ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));

    // A branch that arrives during a memory stall is held in EX/MEM, so it is not counted until the stall clears
    assign w_stall_inc = (r_state != ST_ERROR) & (w_mem_stall | (w_load_use & ~branch_taken));
    assign w_flush_inc = (r_state != ST_ERROR) & ~w_mem_stall & branch_taken;

    // Pipeline-register enables, flushes and bubble, chosen by priority
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!rst_n || r_state == ST_ERROR) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // EX-operand forwarding; EX/MEM result wins over MEM/WB, and x0 never forwards
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs1) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) begin
            fwd_a = 2'b01;
        end
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs2) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) begin
            fwd_b = 2'b01;
        end
    end

    // Memory-wait FSM next state: MEM_TIMEOUT consecutive stalled cycles end in a sticky ERROR
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    if (r_wait_cnt == WC_LAST) begin
                        w_next_state = ST_ERROR;
                    end else begin
                        w_next_state    = ST_MEM_WAIT;
                        w_next_wait_cnt = r_wait_cnt + WC_W'(1);
                    end
                end else begin
                    w_next_state    = ST_RUN;
                    w_next_wait_cnt = '0;
                end
            end
            default: begin
                w_next_state = ST_ERROR;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Saturating stall and flush performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && r_stall_cnt != CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && r_flush_cnt != CNT_MAX) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign state     = r_state;
    assign mem_err   = (r_state == ST_ERROR);

endmodule
